// File: rtl/fifo_pkg.sv
// Shared sizing for the byte FIFO: default word width and depth,
// plus the pointer-width helper used to size the pointers and the count.
package fifo_pkg;

  localparam int WIDTH_DEF = 32'sd8;
  localparam int DEPTH_DEF = 32'sd4;

  function automatic int calc_aw(input int depth);
    int aw;
    aw = 32'sd0;
    while ((32'sd1 << aw) < depth) begin
      aw = aw + 32'sd1;
    end
    return aw;
  endfunction

  localparam int AW_DEF  = calc_aw(DEPTH_DEF);
  localparam int COUNT_W = AW_DEF + 32'sd1;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// FIFO bookkeeping: read/write pointers, occupancy count, accept decisions
// and the sticky overflow/underflow flags. Holds no data.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = calc_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          wr_ok,
  output logic          rd_ok,
  output logic [AW-1:0] wptr,
  output logic [AW-1:0] rptr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_acc_s, rd_acc_s;

  // Accept decisions use pre-edge state; a same-cycle read makes room on full.
  always_comb begin
    rd_acc_s = rd_en & ~empty;
    wr_acc_s = wr_en & (~full | rd_acc_s);
    rd_ok    = rd_acc_s & ~clr;
    wr_ok    = wr_acc_s & ~clr;
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wptr_d      = {AW{1'b0}};
      rptr_d      = {AW{1'b0}};
      count_d     = {(AW+1){1'b0}};
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (rd_acc_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
      count_d     = count_q + (AW+1)'(wr_acc_s) - (AW+1)'(rd_acc_s);
      overflow_d  = overflow_q | (wr_en & ~wr_acc_s);
      underflow_d = underflow_q | (rd_en & ~rd_acc_s);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= {AW{1'b0}};
      rptr_q      <= {AW{1'b0}};
      count_q     <= {(AW+1){1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wptr      = wptr_q;
  assign rptr      = rptr_q;
  assign count     = count_q;
  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == {(AW+1){1'b0}});
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: rtl/byte_fifo_sync.sv
// Synchronous byte FIFO fed by a falling-edge register stage and drained on
// the rising edge; holds the storage array and the registered read port.
module byte_fifo_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = calc_aw(DEPTH)
) (
  input  logic             CLK,
  input  logic             async_clr,
  input  logic             synchro_clr,
  input  logic [WIDTH-1:0] D,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] Q,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] q_q, q_d;
  logic             wr_ok_s, rd_ok_s;
  logic [AW-1:0]    wptr_s, rptr_s;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ctrl (
    .clk       (CLK),
    .rst       (async_clr),
    .clr       (synchro_clr),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .wr_ok     (wr_ok_s),
    .rd_ok     (rd_ok_s),
    .wptr      (wptr_s),
    .rptr      (rptr_s),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_ok_s) begin
      mem_d[wptr_s] = D;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage is deliberately left uncleared by either reset.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  always_comb begin
    q_d = q_q;
    if (synchro_clr) begin
      q_d = {WIDTH{1'b0}};
    end else if (rd_ok_s) begin
      q_d = mem_q[rptr_s];
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge CLK or posedge async_clr) begin
    if (async_clr) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_byte_fifo_sync.sv
// Bench for byte_fifo_sync: directed test-plan steps then random traffic,
// all fed through a falling-edge register stage and checked against a queue model.
module tb_byte_fifo_sync;

  logic       CLK = 1'b0;
  logic       async_clr;
  logic       synchro_clr;
  logic [7:0] D;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] Q;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  logic [7:0] up_d;
  logic       up_clr;
  logic [7:0] up_q;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q;
  logic       exp_ovf;
  logic       exp_unf;

  byte_fifo_sync dut (
    .CLK         (CLK),
    .async_clr   (async_clr),
    .synchro_clr (synchro_clr),
    .D           (D),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .Q           (Q),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 CLK = ~CLK;

  // Upstream falling-edge register stage with its own synchronous clear.
  always @(negedge CLK) begin
    up_q <= up_clr ? 8'd0 : up_d;
  end
  assign D = up_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".full"}, 32'(full), 32'(mq.size() == 4));
    chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, ".Q"}, 32'(Q), 32'(exp_q));
    chk({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(exp_unf));
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q   = 8'd0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  // One rising edge of traffic; called and returns at posedge+1.
  task automatic step(input string tag, input logic w, input logic r, input logic [7:0] d,
                      input logic sc, input logic uc);
    logic [7:0] dval;
    logic       r_ok;
    logic       w_ok;
    wr_en       = w;
    rd_en       = r;
    up_d        = d;
    up_clr      = uc;
    synchro_clr = sc;
    dval = uc ? 8'd0 : d;
    r_ok = r && (mq.size() > 0);
    w_ok = w && ((mq.size() < 4) || r_ok);
    @(posedge CLK);
    #1;
    if (sc) begin
      model_reset();
    end else begin
      if (r_ok) exp_q = mq.pop_front();
      if (w_ok) mq.push_back(dval);
      if (w && !w_ok) exp_ovf = 1'b1;
      if (r && !r_ok) exp_unf = 1'b1;
    end
    chk_all(tag);
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    synchro_clr = 1'b0;
    up_clr      = 1'b0;
  endtask

  task automatic async_pulse(input string tag);
    async_clr = 1'b1;
    #1;
    model_reset();
    chk_all(tag);
    async_clr = 1'b0;
  endtask

  initial begin
    async_clr   = 1'b1;
    synchro_clr = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    up_d        = 8'd0;
    up_clr      = 1'b0;
    model_reset();
    #12;
    chk_all("reset");
    async_clr = 1'b0;
    @(posedge CLK);
    #1;

    // Async clear mid-cycle after some traffic.
    step("pre_a0", 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    step("pre_a1", 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    step("pre_a2", 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
    chk("pre_a.Qnz", 32'(Q), 32'h5A);
    async_pulse("async_clr");
    chk("async.Q0", 32'(Q), 32'h0);

    // Synchronous clear, taking effect at the edge.
    step("pre_s0", 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    step("pre_s1", 1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
    step("pre_s2", 1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
    chk("pre_s.cnt", 32'(count), 32'd2);
    step("sync_clr", 1'b1, 1'b1, 8'h44, 1'b1, 1'b0);
    chk("sync.cnt0", 32'(count), 32'd0);

    // Fill, overflow, drain.
    step("fill0", 1'b1, 1'b0, 8'd1, 1'b0, 1'b0);
    step("fill1", 1'b1, 1'b0, 8'd10, 1'b0, 1'b0);
    step("fill2", 1'b1, 1'b0, 8'd12, 1'b0, 1'b0);
    step("fill3", 1'b1, 1'b0, 8'd16, 1'b0, 1'b0);
    chk("fill.full", 32'(full), 32'd1);
    step("ovf", 1'b1, 1'b0, 8'd32, 1'b0, 1'b0);
    chk("ovf.flag", 32'(overflow), 32'd1);
    step("drain0", 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    chk("drain0.Q", 32'(Q), 32'd1);
    step("drain1", 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    step("drain2", 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    step("drain3", 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    chk("drain3.Q", 32'(Q), 32'd16);
    chk("drain.empty", 32'(empty), 32'd1);

    // Simultaneous write+read on full, across pointer wrap.
    step("sclr1", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    step("wrap_f0", 1'b1, 1'b0, 8'd1, 1'b0, 1'b0);
    step("wrap_f1", 1'b1, 1'b0, 8'd10, 1'b0, 1'b0);
    step("wrap_f2", 1'b1, 1'b0, 8'd12, 1'b0, 1'b0);
    step("wrap_f3", 1'b1, 1'b0, 8'd16, 1'b0, 1'b0);
    step("wr_rd_full", 1'b1, 1'b1, 8'd63, 1'b0, 1'b0);
    chk("wr_rd_full.Q", 32'(Q), 32'd1);
    chk("wr_rd_full.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) step("wrap_drain", 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    chk("wrap_drain.Q", 32'(Q), 32'd63);

    // Underflow, then write+read on empty (no fall-through).
    step("unf", 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    chk("unf.flag", 32'(underflow), 32'd1);
    step("wr_rd_empty", 1'b1, 1'b1, 8'd32, 1'b0, 1'b0);
    chk("wr_rd_empty.Q", 32'(Q), 32'd63);
    step("rd_after", 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    chk("rd_after.Q", 32'(Q), 32'd32);

    // Upstream chain with the register's own clear mid-stream.
    step("sclr2", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    step("chain0", 1'b1, 1'b0, 8'd1, 1'b0, 1'b0);
    step("chain1", 1'b1, 1'b0, 8'd10, 1'b0, 1'b0);
    step("chain2", 1'b1, 1'b0, 8'd12, 1'b0, 1'b1);
    step("chain3", 1'b1, 1'b0, 8'd16, 1'b0, 1'b0);
    step("chain_r0", 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    step("chain_r1", 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    step("chain_r2", 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    chk("chain.zero", 32'(Q), 32'd0);
    step("chain_r3", 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    chk("chain.last", 32'(Q), 32'd16);

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        async_pulse("rnd_async");
      end else begin
        step("rnd", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
             8'($urandom_range(0, 255)), 1'($urandom_range(0, 39) == 0),
             1'($urandom_range(0, 29) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_fifo_sync.md
Name: byte_fifo_sync

Overview:
- Small synchronous FIFO that buffers 8-bit words produced by the falling-edge 8-bit register stage (ports D/CLK/synchro_clr/Q).
- Sits directly downstream of that stage and samples its Q on the rising edge of the same CLK, half a cycle after capture.
- Decouples the register stage from a consumer that drains words at its own rate.
- Provides full/empty/count status and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 8, data word width.
- DEPTH, 4, number of storage entries; must be a power of two, 2 or greater.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- async_clr  in  1  asynchronous active-high reset.
- synchro_clr  in  1  synchronous clear; same effect as reset, applied at a rising edge.
- D  in  WIDTH  write data, driven by the upstream register Q.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- Q  out  WIDTH  read data, registered.
- full  out  1  asserted when count == DEPTH.
- empty  out  1  asserted when count == 0.
- count  out  AW+1  number of stored words, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected because the FIFO was full.
- underflow  out  1  sticky: a read was rejected because the FIFO was empty.

Behaviour:
- Reset (async_clr=1, immediate, asynchronous):
  - Write and read pointers = 0, count = 0.
  - Q = 0, empty = 1, full = 0, overflow = 0, underflow = 0.
  - Storage array contents are not cleared.
- synchro_clr=1 at a rising edge:
  - Same result as reset.
  - Takes priority over wr_en and rd_en in that cycle; no write or read occurs.
- Accept rules, evaluated on pre-edge state:
  - rd_ok = rd_en & !empty.
  - wr_ok = wr_en & (!full | rd_ok).
  - A write into a full FIFO is therefore accepted only when a read is accepted in the same cycle.
  - When empty, simultaneous wr_en+rd_en: the write is accepted, the read is rejected and underflow is set. There is no fall-through.
- Write:
  - mem[wptr] <= D.
  - wptr increments modulo DEPTH; wrap from DEPTH-1 to 0 is natural pointer rollover.
- Read:
  - Q <= mem[rptr].
  - rptr increments modulo DEPTH.
  - Read latency is 1 cycle: data appears on Q after the rising edge at which rd_ok is true.
  - Q holds its last value when no read is accepted.
- count update:
  - count + wr_ok - rd_ok.
  - Never exceeds DEPTH and never goes below 0.
- Status flags:
  - full and empty are combinational decodes of the registered count.
  - They are valid throughout the cycle following an update.
- Sticky error flags:
  - overflow is set by wr_en & !wr_ok.
  - underflow is set by rd_en & !rd_ok.
  - Both stay set until async_clr or synchro_clr.
  - A rejected access changes no other state.
- Ordering: strict FIFO order is preserved across pointer wrap.
- Reset mid-operation: any buffered words are discarded. The first write after reset lands in entry 0.
- Timing relative to upstream:
  - D is stable at the rising edge because the upstream stage updates on the falling edge.
  - No extra synchroniser is required.

Decomposition:
- Shared package (fifo_pkg) holds:
  - WIDTH default (8).
  - DEPTH default (4).
  - Localparam function computing AW from DEPTH.
  - COUNT_W = AW+1.
- One natural sub-module: fifo_ptr_ctrl.
  - Contains the pointers, count, accept logic and sticky flags.
  - The top level holds only the storage array and the Q register.

Test Plan:
- Reset/clear:
  - Stimulus: write 3 words, then pulse async_clr between edges.
  - Required: count=0, empty=1 and Q=0 immediately.
  - Repeat using synchro_clr: same values, taking effect at the next rising edge.
- Fill and drain:
  - Stimulus: write 1, 10, 12, 16 on consecutive edges.
  - Required: full=1, count=4.
  - Then read 4 times: Q=1, 10, 12, 16, each one cycle after its rd_en; empty=1 at the end.
- Overflow:
  - Stimulus: with the FIFO full, wr_en=1, D=32, rd_en=0.
  - Required: overflow=1, count stays 4, and draining returns the original 4 words without 32.
- Simultaneous on full:
  - Stimulus: full with 1, 10, 12, 16; assert wr_en (D=63) and rd_en together.
  - Required: Q=1, count stays 4.
  - Subsequent reads return 10, 12, 16, 63 (checks wrap).
- Underflow and empty simultaneous:
  - Stimulus: empty FIFO; rd_en=1 alone.
  - Required: underflow=1, Q unchanged.
  - Then wr_en+rd_en with D=32: count=1, Q unchanged, and the next read gives Q=32.
- Upstream chain:
  - Stimulus: connect the 8-bit register Q to D; drive its D with 1, 10, 12, 16 and toggle synchro_clr on the register only.
  - Required: the FIFO stores the register outputs, including the 0 produced by the register's clear, in order.
